soc_system_command_fifo_pio: RTL

//  Avalon-MM slave command port from the HPS to the printer motion/heater logic. Successor to the single-register

---
 rtl/soc_system_command_fifo_pio_if.sv | 24 ++
 rtl/soc_system_command_fifo_pio.sv | 110 +++++++++++
 2 files changed

// File: rtl/soc_system_command_fifo_pio_if.sv
// Avalon-MM slave bus plus command stream and IRQ for the HPS command FIFO.
interface soc_system_command_fifo_pio_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [1:0]            address;
  logic                  chipselect;
  logic                  write_n;
  logic [31:0]           writedata;
  logic [31:0]           readdata;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  irq_low;

  modport slave (
    input  address, chipselect, write_n, writedata, out_ready,
    output readdata, out_data, out_valid, irq_low
  );

  modport master (
    output address, chipselect, write_n, writedata, out_ready,
    input  readdata, out_data, out_valid, irq_low
  );
endinterface

// File: rtl/soc_system_command_fifo_pio.sv
// HPS command FIFO: Avalon-MM writes queue commands that leave on a valid/ready stream,
// with status/level readback, flush, sticky overflow and a low-water interrupt.
module soc_system_command_fifo_pio #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input logic                         clk,
  input logic                         reset,
  soc_system_command_fifo_pio_if.slave bus
);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LEVEL_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LEVEL_W-1:0]    level_q, level_d, thresh_q, thresh_d;
  logic                  overflow_q, overflow_d, out_en_q, out_en_d, irq_q, irq_d;

  logic wr, push_req, ctrl_wr, thresh_wr, flush, full, empty, pop_ok, push_ok;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign push_req  = wr & (bus.address == 2'd0);
  assign ctrl_wr   = wr & (bus.address == 2'd2);
  assign thresh_wr = wr & (bus.address == 2'd3);
  assign flush     = ctrl_wr & bus.writedata[1];
  assign full      = (level_q == LEVEL_W'(DEPTH));
  assign empty     = (level_q == '0);
  assign pop_ok    = bus.out_valid & bus.out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = push_req & (~full | pop_ok);

  assign bus.out_valid = ~empty & out_en_q;
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.irq_low   = irq_q;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    out_en_d   = out_en_q;
    thresh_d   = thresh_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
      else if (pop_ok && !push_ok) level_d = level_q - 1'b1;
    end
    if (ctrl_wr) begin
      out_en_d = bus.writedata[0];
      if (bus.writedata[2]) overflow_d = 1'b0;
    end
    // Set is ordered after clear so it wins.
    if (push_req && !push_ok && !flush) overflow_d = 1'b1;
    if (thresh_wr) thresh_d = bus.writedata[LEVEL_W-1:0];
    irq_d = out_en_q & (level_d <= thresh_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      out_en_q   <= 1'b1;
      thresh_q   <= LEVEL_W'(DEPTH / 4);
      irq_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      out_en_q   <= out_en_d;
      thresh_q   <= thresh_d;
      irq_q      <= irq_d;
    end
  end

  // Storage needs no reset; validity is tracked by level.
  always_ff @(posedge clk) begin
    if (!reset && push_ok && !flush) mem_q[wr_ptr_q] <= bus.writedata[DATA_WIDTH-1:0];
  end

  logic [31:0] head_word, status_word;

  always_comb begin
    head_word = '0;
    if (!empty) head_word[DATA_WIDTH-1:0] = bus.out_data;
    status_word                = '0;
    status_word[31]            = full;
    status_word[30]            = empty;
    status_word[29]            = overflow_q;
    status_word[28]            = out_en_q;
    status_word[LEVEL_W-1:0]   = level_q;
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0:    bus.readdata = head_word;
      2'd1:    bus.readdata = status_word;
      2'd2:    bus.readdata = {31'b0, out_en_q};
      default: bus.readdata[LEVEL_W-1:0] = thresh_q;
    endcase
  end
endmodule
